kmer_hash_decoder: RTL

- Inverse of the k-mer rolling-hash encoder: accepts one base-4 k-mer hash word and streams its K nucleotides back out as ASCII characters, one per handshake, first (oldest) base first.
- Sits on the debug/readback path after the hashing stage, so hash tables and minimizer results can be dumped as sequences.
- Valid/ready on both sides; one k-mer in flight; a new hash can be accepted in the same cycle as the last character of the previous one.

---
 rtl/kmer_hash_decoder.sv | 109 ++++++++++
 1 files changed

// File: rtl/kmer_hash_decoder.sv
// kmer_hash_decoder: expands one base-4 k-mer hash word back into K ASCII
// nucleotides, oldest base first, over a valid/ready character stream.
// A new hash is taken on the last character beat so streams run gap-free.
module kmer_hash_decoder #(
  parameter int K      = 4,
  parameter int HASH_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hash_valid,
  output logic              hash_ready,
  input  logic [HASH_W-1:0] hash_in,
  output logic              char_valid,
  input  logic              char_ready,
  output logic [7:0]        char_out,
  output logic              char_last,
  output logic              char_err
);

  localparam int SW    = 2 * K;
  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SW-1:0]    r_shreg;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic             w_last;
  logic             w_accept;
  logic             w_char_hs;
  logic             w_hi_err;

  // Parameter sanity: reject illegal k-mer lengths at elaboration
  if (K < 1 || K > 16) begin : g_bad_k
    $error("kmer_hash_decoder: K must be in 1..16");
  end
  if (SW > HASH_W) begin : g_bad_w
    $error("kmer_hash_decoder: 2*K exceeds HASH_W");
  end

  // Bits above the k-mer field only exist when the hash word is wider
  if (HASH_W > SW) begin : g_hi
    assign w_hi_err = |hash_in[HASH_W-1:SW];
  end else begin : g_nohi
    assign w_hi_err = 1'b0;
  end

  function automatic logic [7:0] f_map(input logic [1:0] d);
    case (d)
      2'd0:    f_map = 8'd65;  // A
      2'd1:    f_map = 8'd84;  // T
      2'd2:    f_map = 8'd67;  // C
      default: f_map = 8'd71;  // G
    endcase
  endfunction

  assign w_last    = (r_cnt == CNT_W'(K - 1));
  assign w_accept  = hash_valid & hash_ready;
  assign w_char_hs = char_valid & char_ready;
  assign char_out  = f_map(r_shreg[SW-1 -: 2]);

  // State register; reset wins over any handshake in the same cycle
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and handshake outputs; hash_ready follows char_ready on the last beat
  always_comb begin
    w_state_nxt = r_state;
    hash_ready  = 1'b0;
    char_valid  = 1'b0;
    char_last   = 1'b0;
    char_err    = 1'b0;
    case (r_state)
      S_IDLE: begin
        hash_ready = 1'b1;
        if (hash_valid) w_state_nxt = S_SEND;
      end
      S_SEND: begin
        char_valid = 1'b1;
        char_last  = w_last;
        char_err   = r_err;
        hash_ready = w_last & char_ready;
        if (char_ready && w_last && !hash_valid) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: load on accept, shift one base per non-final character handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_shreg <= hash_in[SW-1:0];
      r_err   <= w_hi_err;
      r_cnt   <= '0;
    end else if (w_char_hs && !w_last) begin
      r_shreg <= r_shreg << 2;
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

endmodule
